// File: rtl/mp_mac_acc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mp_mac_acc_pkg
// Description : Shared types for the multi-precision MAC accumulator (MacCfg):
//               MAC mode, lane number type, FSM state and lane-count helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package mp_mac_acc_pkg;

  // Multiply mode selected per group
  typedef enum logic [2:0] {
    XNOR = 3'd0,
    M1   = 3'd1,
    M2   = 3'd2,
    M4   = 3'd3,
    M8   = 3'd4
  } mac_mode_e;

  // Interpretation of the lanes of one operand
  typedef enum logic {
    SIGNED   = 1'b0,
    UNSIGNED = 1'b1
  } num_t_e;

  // Group sequencing state
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } mac_state_e;

  // Multi-bit precisions handled by the lane-product tree: 2, 4 and 8 bits
  localparam int c_NUM_PREC = 3;

  // Lane width for precision index p (0 -> 2 bits, 1 -> 4 bits, 2 -> 8 bits)
  function automatic int lane_bits(input int p);
    return 2 << p;
  endfunction

  // Number of lanes of width bits in a dwd-bit word
  function automatic int lane_count(input int dwd, input int bits);
    return dwd / bits;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mp_lane_dot.sv
`default_nettype none
// ============================================================================
// Module      : mp_lane_dot
// Description : Combinational lane-wise dot product of two pixel words at
//               XNOR / 1 / 2 / 4 / 8-bit precision, sign-extended to ODWD.
// Revision    : 1.0 - initial release
// ============================================================================
module mp_lane_dot
  import mp_mac_acc_pkg::*;
#(
  parameter int DWD  = 16,
  parameter int ODWD = 24
) (
  input  logic [2:0]             i_mode,
  input  logic                   i_inumt,
  input  logic                   i_wnumt,
  input  logic [DWD-1:0]         i_ipix,
  input  logic [DWD-1:0]         i_wpix,
  output logic signed [ODWD-1:0] o_psum
);

  logic signed [ODWD-1:0] w_prec_sum [c_NUM_PREC];
  logic signed [ODWD-1:0] w_and_pop;
  logic signed [ODWD-1:0] w_xnor_pop;

  assign w_and_pop  = ODWD'($countones(i_ipix & i_wpix));
  assign w_xnor_pop = ODWD'($countones(i_ipix ~^ i_wpix));

  for (genvar p = 0; p < c_NUM_PREC; p++) begin : g_prec
    localparam int B  = lane_bits(p);
    localparam int NL = lane_count(DWD, B);

    logic [DWD-1:0]         w_ip;
    logic [DWD-1:0]         w_wp;
    logic signed [B:0]      w_a;
    logic signed [B:0]      w_w;
    logic signed [ODWD-1:0] w_sum;

    // Walk the lanes LSB first, extending each to B+1 bits before multiplying
    always_comb begin
      w_ip  = i_ipix;
      w_wp  = i_wpix;
      w_a   = '0;
      w_w   = '0;
      w_sum = '0;
      for (int l = 0; l < NL; l++) begin
        w_a   = {(i_inumt == SIGNED) & w_ip[B-1], w_ip[B-1:0]};
        w_w   = {(i_wnumt == SIGNED) & w_wp[B-1], w_wp[B-1:0]};
        w_sum = w_sum + ODWD'(w_a) * ODWD'(w_w);
        w_ip  = w_ip >> B;
        w_wp  = w_wp >> B;
      end
    end

    assign w_prec_sum[p] = w_sum;
  end

  // Select the partial sum for the requested mode; unknown modes behave as M8
  always_comb begin
    o_psum = w_prec_sum[2];
    case (mac_mode_e'(i_mode))
      XNOR:    o_psum = (w_xnor_pop <<< 1) - ODWD'(DWD);
      M1:      o_psum = (i_inumt != i_wnumt) ? -w_and_pop : w_and_pop;
      M2:      o_psum = w_prec_sum[0];
      M4:      o_psum = w_prec_sum[1];
      default: o_psum = w_prec_sum[2];
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mp_mac_acc.sv
`default_nettype none
// ============================================================================
// Module      : mp_mac_acc
// Description : Two-stage pipelined multi-precision dot-product accumulator.
//               Stage 1 registers the beat's lane dot product, stage 2 sums
//               i_acc_len beats; the result is held until consumed.
//               Optional macro MAC_SAT_EN: saturating accumulation and a
//               sticky o_sat overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module mp_mac_acc
  import mp_mac_acc_pkg::*;
#(
  parameter int DWD   = 16,
  parameter int ODWD  = 24,
  parameter int LENWD = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [2:0]             i_mode,
  input  logic                   i_iNumT,
  input  logic                   i_wNumT,
  input  logic [LENWD-1:0]       i_acc_len,
  input  logic [DWD-1:0]         i_ipix,
  input  logic [DWD-1:0]         i_wpix,
  input  logic                   i_valid,
  output logic                   o_ready,
  output logic signed [ODWD-1:0] o_sum,
  output logic                   o_valid,
`ifdef MAC_SAT_EN
  output logic                   o_sat,
`endif
  input  logic                   i_ready
);

  mac_state_e             r_state;
  mac_state_e             w_state_nxt;
  logic [2:0]             r_mode;
  logic                   r_inumt;
  logic                   r_wnumt;
  logic [LENWD-1:0]       r_len;
  logic [LENWD-1:0]       r_cnt;
  logic signed [ODWD-1:0] r_psum;
  logic                   r_s1_valid;
  logic                   r_s1_first;
  logic                   r_s1_last;
  logic signed [ODWD-1:0] r_acc;
  logic                   r_acc_last;
  logic signed [ODWD-1:0] r_sum;
  logic signed [ODWD-1:0] w_psum;
  logic signed [ODWD-1:0] w_acc_nxt;
  logic                   w_accept;
  logic                   w_first;
  logic                   w_last_beat;

  assign w_accept = i_valid && o_ready;
  assign w_first  = (r_state == IDLE);
  // The first beat of a group decides from its own len (0 and 1 both mean one beat)
  assign w_last_beat = w_first ? (i_acc_len <= LENWD'(1)) : ((r_cnt + 1'b1) == r_len);
  assign o_sum = r_sum;

  // The first beat uses live configuration, later beats the latched copy
  mp_lane_dot #(
    .DWD  (DWD),
    .ODWD (ODWD)
  ) u_lane_dot (
    .i_mode  (w_first ? i_mode  : r_mode),
    .i_inumt (w_first ? i_iNumT : r_inumt),
    .i_wnumt (w_first ? i_wNumT : r_wnumt),
    .i_ipix  (i_ipix),
    .i_wpix  (i_wpix),
    .o_psum  (w_psum)
  );

`ifdef MAC_SAT_EN
  localparam logic signed [ODWD-1:0] c_SAT_MAX = {1'b0, {(ODWD-1){1'b1}}};
  localparam logic signed [ODWD-1:0] c_SAT_MIN = {1'b1, {(ODWD-1){1'b0}}};

  logic signed [ODWD:0] w_acc_wide;
  logic                 w_ovf;
  logic                 r_sat;

  assign w_acc_wide = {r_acc[ODWD-1], r_acc} + {r_psum[ODWD-1], r_psum};
  assign w_ovf      = w_acc_wide[ODWD] != w_acc_wide[ODWD-1];
  assign w_acc_nxt  = w_ovf ? (w_acc_wide[ODWD] ? c_SAT_MIN : c_SAT_MAX) : w_acc_wide[ODWD-1:0];
  assign o_sat      = r_sat;

  // Sticky overflow flag, restarted by the first psum of each group
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_sat <= 1'b0;
    end else if (r_s1_valid) begin
      r_sat <= r_s1_first ? 1'b0 : (r_sat | w_ovf);
    end
  end
`else
  assign w_acc_nxt = r_acc + r_psum;
`endif

  // State register
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    o_ready     = 1'b0;
    o_valid     = 1'b0;
    case (r_state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) w_state_nxt = w_last_beat ? DRAIN : ACC;
      end
      ACC: begin
        o_ready = 1'b1;
        if (i_valid && w_last_beat) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (r_acc_last) w_state_nxt = HOLD;
      end
      HOLD: begin
        o_valid = 1'b1;
        if (i_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Latch group configuration on the first beat and count accepted beats
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_mode  <= '0;
      r_inumt <= 1'b0;
      r_wnumt <= 1'b0;
      r_len   <= LENWD'(1);
      r_cnt   <= '0;
    end else if (w_accept) begin
      if (w_first) begin
        r_mode  <= i_mode;
        r_inumt <= i_iNumT;
        r_wnumt <= i_wNumT;
        r_len   <= (i_acc_len == '0) ? LENWD'(1) : i_acc_len;
        r_cnt   <= LENWD'(1);
      end else begin
        r_cnt   <= r_cnt + 1'b1;
      end
    end
  end

  // Stage 1: register the beat's psum with its group-position tags
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_s1_valid <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
      r_psum     <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_first <= w_first;
        r_s1_last  <= w_last_beat;
        r_psum     <= w_psum;
      end
    end
  end

  // Stage 2: load on the first psum, accumulate afterwards
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_acc      <= '0;
      r_acc_last <= 1'b0;
    end else begin
      r_acc_last <= r_s1_valid && r_s1_last;
      if (r_s1_valid) begin
        r_acc <= r_s1_first ? r_psum : w_acc_nxt;
      end
    end
  end

  // Capture the finished group into the held output register
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_sum <= '0;
    end else if (r_state == DRAIN && r_acc_last) begin
      r_sum <= r_acc;
    end
  end

endmodule
`default_nettype wire
